// File: rtl/ctrl_pipe_stallable_pkg.sv
// Shared constants for the stallable control pipeline: ARM condition codes,
// NZCV bit positions and the widths/field positions of each stage bundle.
package ctrl_pipe_stallable_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // D->E bundle: 14 control bits, the ALU field, then a 4-bit tag (valid in bit 0).
    localparam int DE_CTRL_W = 14;
    localparam int DE_TAG_W  = 4;

    localparam int M_W = 4;
    localparam int M_REGWRITE = 3;
    localparam int M_MEMWRITE = 2;
    localparam int M_MEMTOREG = 1;
    localparam int M_PCSRC    = 0;

    localparam int W_W = 3;
    localparam int W_REGWRITE = 2;
    localparam int W_MEMTOREG = 1;
    localparam int W_PCSRC    = 0;

    function automatic int deWidth(input int aluCtrlW);
        return DE_CTRL_W + aluCtrlW + DE_TAG_W;
    endfunction

endpackage

// File: rtl/ctrl_pipe_stallable_cond_eval.sv
// ARM condition evaluator: decides whether the E-stage instruction executes
// given its condition field and the current NZCV flags.
module cond_eval
    import ctrl_pipe_stallable_pkg::*;
(
    input  logic [3:0] CondE,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b1;
        case (CondE)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            default: CondEx = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_stallable.sv
// Control-signal pipeline D -> E -> M1..Mn -> W with per-stage stall/flush,
// an NZCV flag register updated from E, and a pending-PC-write indicator.
module ctrl_pipe_stallable
    import ctrl_pipe_stallable_pkg::*;
#(
    parameter int ALUCTRL_W  = 5,
    parameter int MEM_STAGES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PCSrcD,
    input  logic                 RegWriteD,
    input  logic                 MemtoRegD,
    input  logic                 MemWriteD,
    input  logic                 BranchD,
    input  logic                 ALUSrcD,
    input  logic                 NoWriteD,
    input  logic                 IgRnD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic [1:0]           FlagWriteD,
    input  logic [3:0]           CondD,
    input  logic [3:0]           ALUFlags,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 StallM,
    input  logic                 FlushM,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 IgRnE,
    output logic                 MemtoRegE,
    output logic                 BranchTakenE,
    output logic                 PCSrcE,
    output logic                 CondExE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 MemtoRegM,
    output logic                 PCSrcM,
    output logic                 RegWriteW,
    output logic                 MemtoRegW,
    output logic                 PCSrcW,
    output logic [3:0]           Flags,
    output logic                 PCWrPending
);

    localparam int DE_W = deWidth(ALUCTRL_W);

    logic stallEEff;
    assign stallEEff = StallE | StallM;

    logic [DE_W-1:0] deStage_d, deStage_q;

    // The valid tag distinguishes a real instruction from a flush/reset bubble.
    assign deStage_d = {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD,
                        NoWriteD, IgRnD, FlagWriteD, CondD, ALUControlD, 3'b000, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            deStage_q <= '0;
        else if (FlushE)
            deStage_q <= '0;
        else if (!stallEEff)
            deStage_q <= deStage_d;
    end

    logic                 ePcSrc, eRegWrite, eMemtoReg, eMemWrite, eBranch;
    logic                 eAluSrc, eNoWrite, eIgRn, eValid;
    logic [1:0]           eFlagWrite;
    logic [3:0]           eCond;
    logic [ALUCTRL_W-1:0] eAluControl;
    logic [2:0]           unusedSpareE;

    assign {ePcSrc, eRegWrite, eMemtoReg, eMemWrite, eBranch, eAluSrc, eNoWrite, eIgRn,
            eFlagWrite, eCond, eAluControl, unusedSpareE, eValid} = deStage_q;

    logic [3:0] flags_q;
    logic       condPass, condExE;

    cond_eval uCondEval (
        .CondE  (eCond),
        .Flags  (flags_q),
        .CondEx (condPass)
    );

    assign condExE = condPass & eValid;

    logic [M_W-1:0] mEntry;
    assign mEntry = {eRegWrite & condExE & ~eNoWrite, eMemWrite & condExE,
                     eMemtoReg, ePcSrc & condExE};

    logic [M_W-1:0]        mStageOut [MEM_STAGES];
    logic [MEM_STAGES-1:0] mPcSrc;

    for (genvar i = 0; i < MEM_STAGES; i++) begin : gMem
        logic [M_W-1:0] stage_d, stage_q;

        if (i == 0) begin : gFirst
            assign stage_d = (FlushM | stallEEff) ? '0 : mEntry;
        end else begin : gRest
            assign stage_d = mStageOut[i-1];
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                stage_q <= '0;
            else if (!StallM)
                stage_q <= stage_d;
        end

        assign mStageOut[i] = stage_q;
        assign mPcSrc[i]    = stage_q[M_PCSRC];
    end

    logic [M_W-1:0] mLast;
    assign mLast = mStageOut[MEM_STAGES-1];

    logic [W_W-1:0] wStage_d, wStage_q;
    assign wStage_d = StallM ? '0 : {mLast[M_REGWRITE], mLast[M_MEMTOREG], mLast[M_PCSRC]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wStage_q <= '0;
        else
            wStage_q <= wStage_d;
    end

    // Flags change only on the edge where the E instruction actually leaves E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
        end else if (!stallEEff && !FlushE && condExE) begin
            if (eFlagWrite[1])
                flags_q[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            if (eFlagWrite[0])
                flags_q[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
        end
    end

    assign ALUControlE  = eAluControl;
    assign ALUSrcE      = eAluSrc;
    assign IgRnE        = eIgRn;
    assign MemtoRegE    = eMemtoReg;
    assign BranchTakenE = eBranch & condExE;
    assign PCSrcE       = ePcSrc & condExE;
    assign CondExE      = condExE;

    assign RegWriteM = mLast[M_REGWRITE];
    assign MemWriteM = mLast[M_MEMWRITE];
    assign MemtoRegM = mLast[M_MEMTOREG];
    assign PCSrcM    = mLast[M_PCSRC];

    assign RegWriteW = wStage_q[W_REGWRITE];
    assign MemtoRegW = wStage_q[W_MEMTOREG];
    assign PCSrcW    = wStage_q[W_PCSRC];

    assign Flags = flags_q;

    // Held low during reset so every output reads zero while reset is asserted.
    assign PCWrPending = reset & (PCSrcD | ePcSrc | (|mPcSrc));

endmodule

// File: tb/tb_ctrl_pipe_stallable.sv
// Directed bench for ctrl_pipe_stallable: two instances (MEM_STAGES=1 and 2)
// share one stimulus stream so latency differences can be observed side by side.
module tb_ctrl_pipe_stallable;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       PCSrcD = 1'b0, RegWriteD = 1'b0, MemtoRegD = 1'b0, MemWriteD = 1'b0;
    logic       BranchD = 1'b0, ALUSrcD = 1'b0, NoWriteD = 1'b0, IgRnD = 1'b0;
    logic [4:0] ALUControlD = '0;
    logic [1:0] FlagWriteD = '0;
    logic [3:0] CondD = '0;
    logic [3:0] ALUFlags = '0;
    logic       StallE = 1'b0, FlushE = 1'b0, StallM = 1'b0, FlushM = 1'b0;

    logic [4:0] ALUControlE1, ALUControlE2;
    logic       ALUSrcE1, IgRnE1, MemtoRegE1, BranchTakenE1, PCSrcE1, CondExE1;
    logic       ALUSrcE2, IgRnE2, MemtoRegE2, BranchTakenE2, PCSrcE2, CondExE2;
    logic       RegWriteM1, MemWriteM1, MemtoRegM1, PCSrcM1;
    logic       RegWriteM2, MemWriteM2, MemtoRegM2, PCSrcM2;
    logic       RegWriteW1, MemtoRegW1, PCSrcW1, PCWrPending1;
    logic       RegWriteW2, MemtoRegW2, PCSrcW2, PCWrPending2;
    logic [3:0] Flags1, Flags2;

    int passCount  = 0;
    int totalCount = 0;

    always #5 clk = ~clk;

    ctrl_pipe_stallable #(.ALUCTRL_W(5), .MEM_STAGES(1)) dut1 (
        .clk(clk), .reset(reset),
        .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .NoWriteD(NoWriteD), .IgRnD(IgRnD),
        .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .CondD(CondD), .ALUFlags(ALUFlags),
        .StallE(StallE), .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM),
        .ALUControlE(ALUControlE1), .ALUSrcE(ALUSrcE1), .IgRnE(IgRnE1), .MemtoRegE(MemtoRegE1),
        .BranchTakenE(BranchTakenE1), .PCSrcE(PCSrcE1), .CondExE(CondExE1),
        .RegWriteM(RegWriteM1), .MemWriteM(MemWriteM1), .MemtoRegM(MemtoRegM1), .PCSrcM(PCSrcM1),
        .RegWriteW(RegWriteW1), .MemtoRegW(MemtoRegW1), .PCSrcW(PCSrcW1),
        .Flags(Flags1), .PCWrPending(PCWrPending1)
    );

    ctrl_pipe_stallable #(.ALUCTRL_W(5), .MEM_STAGES(2)) dut2 (
        .clk(clk), .reset(reset),
        .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .NoWriteD(NoWriteD), .IgRnD(IgRnD),
        .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .CondD(CondD), .ALUFlags(ALUFlags),
        .StallE(StallE), .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM),
        .ALUControlE(ALUControlE2), .ALUSrcE(ALUSrcE2), .IgRnE(IgRnE2), .MemtoRegE(MemtoRegE2),
        .BranchTakenE(BranchTakenE2), .PCSrcE(PCSrcE2), .CondExE(CondExE2),
        .RegWriteM(RegWriteM2), .MemWriteM(MemWriteM2), .MemtoRegM(MemtoRegM2), .PCSrcM(PCSrcM2),
        .RegWriteW(RegWriteW2), .MemtoRegW(MemtoRegW2), .PCSrcW(PCSrcW2),
        .Flags(Flags2), .PCWrPending(PCWrPending2)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic pcSrc, input logic regWrite, input logic memtoReg,
                                 input logic memWrite, input logic branch,
                                 input logic [1:0] flagWrite, input logic [3:0] cond,
                                 input logic [4:0] aluCtrl);
        PCSrcD      = pcSrc;
        RegWriteD   = regWrite;
        MemtoRegD   = memtoReg;
        MemWriteD   = memWrite;
        BranchD     = branch;
        FlagWriteD  = flagWrite;
        CondD       = cond;
        ALUControlD = aluCtrl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        #1 reset = 1'b0;
        #2;
        checkOutput("reset CondExE", CondExE1, 8'h0);
        checkOutput("reset Flags", Flags1, 8'h0);
        checkOutput("reset ALUControlE", ALUControlE1, 8'h0);
        checkOutput("reset RegWriteW2", RegWriteW2, 8'h0);
        checkOutput("reset PCWrPending", PCWrPending1, 8'h0);
        @(posedge clk);
        #2 reset = 1'b1;

        // Latency of an unconditional register write through both depths
        applyStimulus(0, 1, 0, 0, 0, 2'b00, 4'hE, 5'h00);
        tick();
        checkOutput("lat CondExE", CondExE1, 8'h1);
        applyStimulus(0, 0, 0, 0, 0, 2'b00, 4'h0, 5'h00);
        tick();
        checkOutput("lat RegWriteM ms1", RegWriteM1, 8'h1);
        checkOutput("lat RegWriteM ms2 early", RegWriteM2, 8'h0);
        tick();
        checkOutput("lat RegWriteM ms2", RegWriteM2, 8'h1);
        checkOutput("lat RegWriteW ms1", RegWriteW1, 8'h1);
        checkOutput("lat RegWriteW ms2 early", RegWriteW2, 8'h0);
        tick();
        checkOutput("lat RegWriteW ms2", RegWriteW2, 8'h1);

        // Reset mid-flight drops in-flight instructions
        applyStimulus(0, 1, 0, 0, 0, 2'b00, 4'hE, 5'h00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 2'b00, 4'h0, 5'h00);
        tick();
        checkOutput("midrst pre RegWriteM", RegWriteM1, 8'h1);
        reset = 1'b0;
        #1;
        checkOutput("midrst RegWriteM", RegWriteM1, 8'h0);
        checkOutput("midrst Flags", Flags1, 8'h0);
        reset = 1'b1;
        tick();
        checkOutput("midrst dropped ms2", RegWriteM2, 8'h0);

        // SUBS sets Z, BEQ taken
        ALUFlags = 4'b0100;
        applyStimulus(0, 1, 0, 0, 0, 2'b11, 4'hE, 5'h02);
        tick();
        applyStimulus(1, 0, 0, 0, 1, 2'b00, 4'h0, 5'h00);
        #1;
        checkOutput("beq PCWrPending D", PCWrPending1, 8'h1);
        tick();
        checkOutput("beq Flags", Flags1, 8'h4);
        checkOutput("beq CondExE", CondExE1, 8'h1);
        checkOutput("beq BranchTakenE", BranchTakenE1, 8'h1);
        checkOutput("beq PCSrcE", PCSrcE1, 8'h1);
        applyStimulus(0, 0, 0, 0, 0, 2'b00, 4'h0, 5'h00);
        tick();
        checkOutput("beq PCSrcM", PCSrcM1, 8'h1);
        tick();
        checkOutput("beq PCSrcW", PCSrcW1, 8'h1);

        // SUBS clears Z, BEQ not taken and leaves flags alone
        ALUFlags = 4'b0000;
        applyStimulus(0, 1, 0, 0, 0, 2'b11, 4'hE, 5'h02);
        tick();
        applyStimulus(1, 0, 0, 0, 1, 2'b00, 4'h0, 5'h00);
        tick();
        checkOutput("bne Flags", Flags1, 8'h0);
        checkOutput("bne BranchTakenE", BranchTakenE1, 8'h0);
        checkOutput("bne CondExE", CondExE1, 8'h0);
        ALUFlags = 4'b1111;
        applyStimulus(0, 0, 0, 0, 0, 2'b00, 4'h0, 5'h00);
        tick();
        checkOutput("bne Flags kept", Flags1, 8'h0);
        checkOutput("bne PCSrcM", PCSrcM1, 8'h0);

        // STRNE with Z=1 suppressed, with Z=0 performed
        ALUFlags = 4'b0100;
        applyStimulus(0, 1, 0, 0, 0, 2'b11, 4'hE, 5'h02);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 2'b00, 4'h1, 5'h00);
        tick();
        checkOutput("strne z1 CondExE", CondExE1, 8'h0);
        applyStimulus(0, 0, 0, 0, 0, 2'b00, 4'h0, 5'h00);
        tick();
        checkOutput("strne z1 MemWriteM", MemWriteM1, 8'h0);
        ALUFlags = 4'b0000;
        applyStimulus(0, 1, 0, 0, 0, 2'b11, 4'hE, 5'h02);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 2'b00, 4'h1, 5'h00);
        tick();
        checkOutput("strne z0 CondExE", CondExE1, 8'h1);
        applyStimulus(0, 0, 0, 0, 0, 2'b00, 4'h0, 5'h00);
        tick();
        checkOutput("strne z0 MemWriteM", MemWriteM1, 8'h1);

        // Two-cycle E stall: single flag update on the advancing edge
        ALUFlags = 4'b1000;
        applyStimulus(0, 1, 0, 0, 0, 2'b10, 4'hE, 5'h15);
        tick();
        StallE = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 2'b00, 4'h0, 5'h00);
        tick();
        checkOutput("stall1 Flags", Flags1, 8'h0);
        checkOutput("stall1 ALUControlE", ALUControlE1, 8'h15);
        checkOutput("stall1 M1 bubble", RegWriteM1, 8'h0);
        ALUFlags = 4'b0100;
        tick();
        checkOutput("stall2 Flags", Flags1, 8'h0);
        checkOutput("stall2 ALUControlE", ALUControlE1, 8'h15);
        checkOutput("stall2 M1 bubble", RegWriteM1, 8'h0);
        StallE = 1'b0;
        tick();
        checkOutput("stall adv Flags", Flags1, 8'h4);
        checkOutput("stall adv RegWriteM", RegWriteM1, 8'h1);
        ALUFlags = 4'b1000;
        tick();
        checkOutput("stall once Flags", Flags1, 8'h4);

        // Flush beats stall in E
        applyStimulus(0, 0, 0, 0, 0, 2'b00, 4'hE, 5'h0A);
        tick();
        checkOutput("flush pre ALUControlE", ALUControlE1, 8'h0A);
        checkOutput("flush pre CondExE", CondExE1, 8'h1);
        applyStimulus(0, 0, 0, 0, 0, 2'b00, 4'h0, 5'h00);
        FlushE = 1'b1;
        StallE = 1'b1;
        tick();
        checkOutput("flush ALUControlE", ALUControlE1, 8'h0);
        checkOutput("flush CondExE", CondExE1, 8'h0);
        FlushE = 1'b0;
        StallE = 1'b0;

        // M stall holds M, bubbles W; FlushM cannot override it
        applyStimulus(1, 1, 0, 0, 0, 2'b00, 4'hE, 5'h00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 2'b00, 4'h0, 5'h00);
        #1;
        checkOutput("pend E PCWrPending", PCWrPending1, 8'h1);
        tick();
        checkOutput("stallM pre PCSrcM", PCSrcM1, 8'h1);
        checkOutput("stallM pre RegWriteM", RegWriteM1, 8'h1);
        checkOutput("pend M PCWrPending", PCWrPending1, 8'h1);
        StallM = 1'b1;
        tick();
        checkOutput("stallM hold RegWriteM", RegWriteM1, 8'h1);
        checkOutput("stallM W bubble RegWrite", RegWriteW1, 8'h0);
        checkOutput("stallM W bubble PCSrc", PCSrcW1, 8'h0);
        FlushM = 1'b1;
        tick();
        checkOutput("stallM+flushM hold", RegWriteM1, 8'h1);
        checkOutput("stallM+flushM pending", PCWrPending1, 8'h1);
        StallM = 1'b0;
        FlushM = 1'b0;
        tick();
        checkOutput("stallM rel RegWriteW", RegWriteW1, 8'h1);
        checkOutput("stallM rel PCSrcW", PCSrcW1, 8'h1);
        checkOutput("stallM rel RegWriteM", RegWriteM1, 8'h0);
        checkOutput("stallM rel PCWrPending", PCWrPending1, 8'h0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
